// File: rtl/nbf_uart_sequencer.sv
// NBF packet engine: serializes command packets to uart_tx, reassembles uart_rx bytes into responses.
// Define NBF_UART_SEQUENCER_CHECK_EN to enable the expected-response FIFO and mismatch_o.
module nbf_uart_sequencer #(
  parameter int nbf_addr_width_p  = 40,
  parameter int nbf_data_width_p  = 64,
  parameter int max_outstanding_p = 4,
  parameter int timeout_cycles_p  = 1000000,
  localparam int nbf_width_lp     = 8 + nbf_addr_width_p + nbf_data_width_p,
  localparam int nbf_bytes_lp     = (nbf_width_lp + 7) / 8,
  localparam int out_width_lp     = $clog2(max_outstanding_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cmd_v_i,
  input  logic [nbf_width_lp-1:0] cmd_i,
  output logic                    cmd_ready_and_o,
  output logic                    tx_v_o,
  output logic [7:0]              tx_o,
  input  logic                    tx_ready_and_i,
  input  logic                    rx_v_i,
  input  logic [7:0]              rx_i,
  output logic                    resp_v_o,
  output logic [nbf_width_lp-1:0] resp_o,
  input  logic                    resp_ready_and_i,
  output logic [out_width_lp-1:0] outstanding_o,
  output logic                    idle_o,
  output logic                    timeout_o,
  output logic                    mismatch_o,
  output logic                    overflow_o
);
  localparam int pad_width_lp = nbf_bytes_lp * 8;
  localparam int idx_width_lp = (nbf_bytes_lp > 1) ? $clog2(nbf_bytes_lp) : 1;
  localparam int to_width_lp  = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;
  localparam logic [idx_width_lp-1:0] last_byte_lp = idx_width_lp'(nbf_bytes_lp - 1);
  localparam logic [to_width_lp-1:0]  to_last_lp   = to_width_lp'(timeout_cycles_p - 1);
  localparam logic [out_width_lp-1:0] max_out_lp   = out_width_lp'(max_outstanding_p);

  typedef enum logic [0:0] {e_idle = 1'b0, e_send = 1'b1} tx_state_e;

  tx_state_e                tx_state_q, tx_state_d;
  logic [pad_width_lp-1:0]  tx_shift_q, tx_shift_d;
  logic [idx_width_lp-1:0]  tx_idx_q, tx_idx_d;
  logic [pad_width_lp-1:0]  rx_asm_q, rx_asm_d;
  logic [idx_width_lp-1:0]  rx_idx_q, rx_idx_d;
  logic                     resp_v_q, resp_v_d;
  logic [nbf_width_lp-1:0]  resp_q, resp_d;
  logic [out_width_lp-1:0]  out_q, out_d;
  logic [to_width_lp-1:0]   to_cnt_q, to_cnt_d;
  logic                     timeout_q, timeout_d;
  logic                     overflow_q, overflow_d;
  logic                     cmd_accept_s, rx_done_s, resp_load_s, to_fire_s;

  assign cmd_ready_and_o = (tx_state_q == e_idle) && (out_q < max_out_lp);
  assign cmd_accept_s    = cmd_v_i && cmd_ready_and_o;
  assign rx_done_s       = rx_v_i && (rx_idx_q == last_byte_lp);
  assign resp_load_s     = rx_done_s && (!resp_v_q || resp_ready_and_i);

  // TX next state: the shift register drains toward byte 0, so idle leaves tx_o at zero.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    case (tx_state_q)
      e_idle: begin
        if (cmd_accept_s) begin
          tx_shift_d = pad_width_lp'(cmd_i);
          tx_idx_d   = '0;
          tx_state_d = e_send;
        end else begin
          tx_state_d = e_idle;
        end
      end
      e_send: begin
        if (tx_ready_and_i) begin
          tx_shift_d = {8'h00, tx_shift_q[pad_width_lp-1:8]};
          tx_idx_d   = tx_idx_q + idx_width_lp'(1);
          if (tx_idx_q == last_byte_lp) begin
            tx_state_d = e_idle;
          end else begin
            tx_state_d = e_send;
          end
        end else begin
          tx_state_d = e_send;
        end
      end
      default: tx_state_d = e_idle;
    endcase
  end

  // RX assembly, response holding register and overflow detection.
  always_comb begin
    rx_asm_d   = rx_asm_q;
    rx_idx_d   = rx_idx_q;
    resp_d     = resp_q;
    resp_v_d   = resp_v_q;
    overflow_d = overflow_q;
    if (rx_v_i) begin
      rx_asm_d[{rx_idx_q, 3'b000} +: 8] = rx_i;
      rx_idx_d = rx_done_s ? '0 : rx_idx_q + idx_width_lp'(1);
    end else if (to_fire_s) begin
      rx_idx_d = '0;
    end else begin
      rx_idx_d = rx_idx_q;
    end
    if (resp_load_s) begin
      resp_d   = rx_asm_d[nbf_width_lp-1:0];
      resp_v_d = 1'b1;
    end else if (resp_v_q && resp_ready_and_i) begin
      resp_v_d = 1'b0;
    end else begin
      resp_v_d = resp_v_q;
    end
    if (rx_done_s && !resp_load_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Outstanding count (saturating at zero) and rx-silence timeout.
  always_comb begin
    out_d     = out_q;
    to_cnt_d  = to_cnt_q;
    to_fire_s = 1'b0;
    timeout_d = timeout_q;
    if (cmd_accept_s && !rx_done_s) begin
      out_d = out_q + out_width_lp'(1);
    end else if (!cmd_accept_s && rx_done_s && (out_q != '0)) begin
      out_d = out_q - out_width_lp'(1);
    end else begin
      out_d = out_q;
    end
    if ((out_q == '0) || rx_v_i) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == to_last_lp) begin
      to_cnt_d  = '0;
      to_fire_s = 1'b1;
      timeout_d = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + to_width_lp'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state_q <= e_idle;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      rx_asm_q   <= '0;
      rx_idx_q   <= '0;
      resp_q     <= '0;
      resp_v_q   <= 1'b0;
      out_q      <= '0;
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      rx_asm_q   <= rx_asm_d;
      rx_idx_q   <= rx_idx_d;
      resp_q     <= resp_d;
      resp_v_q   <= resp_v_d;
      out_q      <= out_d;
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef NBF_UART_SEQUENCER_CHECK_EN
  localparam int key_width_lp = 8 + nbf_addr_width_p;
  localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(max_outstanding_p - 1);

  function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_last_lp) ? '0 : p + ptr_width_lp'(1);
  endfunction

  logic [key_width_lp-1:0] exp_mem_q [max_outstanding_p];
  logic [ptr_width_lp-1:0] wr_ptr_q, rd_ptr_q;
  logic                    mismatch_q, mismatch_d, pop_s;

  // FIFO occupancy always equals the outstanding count, so out_q doubles as its fill level.
  assign pop_s = rx_done_s && (out_q != '0);

  // Response key check against the oldest issued command.
  always_comb begin
    mismatch_d = mismatch_q;
    if (rx_done_s && ((out_q == '0) || (rx_asm_d[key_width_lp-1:0] != exp_mem_q[rd_ptr_q]))) begin
      mismatch_d = 1'b1;
    end else begin
      mismatch_d = mismatch_q;
    end
  end

  // Expected-key storage.
  always_ff @(posedge clk_i) begin
    if (cmd_accept_s) exp_mem_q[wr_ptr_q] <= cmd_i[key_width_lp-1:0];
  end

  // FIFO pointers and sticky mismatch flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (cmd_accept_s) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop_s)        rd_ptr_q <= ptr_next(rd_ptr_q);
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch_o = mismatch_q;
`else
  assign mismatch_o = 1'b0;
`endif

  assign tx_v_o        = (tx_state_q == e_send);
  assign tx_o          = tx_shift_q[7:0];
  assign resp_v_o      = resp_v_q;
  assign resp_o        = resp_q;
  assign outstanding_o = out_q;
  assign timeout_o     = timeout_q;
  assign overflow_o    = overflow_q;
  assign idle_o        = (tx_state_q == e_idle) && (rx_idx_q == '0) && (out_q == '0) && !resp_v_q;

endmodule

// File: tb/tb_nbf_uart_sequencer.sv
// Self-checking bench for nbf_uart_sequencer with randomized packets and a queue-based reference model.
module tb_nbf_uart_sequencer;
  localparam int A    = 40;
  localparam int D    = 64;
  localparam int W    = 8 + A + D;
  localparam int NB   = (W + 7) / 8;
  localparam int MAXO = 4;
  localparam int TO   = 100;
`ifdef NBF_UART_SEQUENCER_CHECK_EN
  localparam bit EXP_MM = 1'b1;
`else
  localparam bit EXP_MM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, cmd_v, cmd_ready, tx_v, tx_ready, rx_v, resp_v, resp_ready;
  logic [W-1:0] cmd, resp;
  logic [7:0]   tx, rx;
  logic [2:0]   outstanding;
  logic         idle, timeout, mismatch, overflow;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  logic [7:0]   tx_log [$];
  logic [W-1:0] issued [$];

  nbf_uart_sequencer #(
    .nbf_addr_width_p(A), .nbf_data_width_p(D),
    .max_outstanding_p(MAXO), .timeout_cycles_p(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_v_i(cmd_v), .cmd_i(cmd), .cmd_ready_and_o(cmd_ready),
    .tx_v_o(tx_v), .tx_o(tx), .tx_ready_and_i(tx_ready),
    .rx_v_i(rx_v), .rx_i(rx),
    .resp_v_o(resp_v), .resp_o(resp), .resp_ready_and_i(resp_ready),
    .outstanding_o(outstanding), .idle_o(idle),
    .timeout_o(timeout), .mismatch_o(mismatch), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!reset && tx_v && tx_ready) tx_log.push_back(tx);
  end

  function automatic logic [W-1:0] mk_pkt(input logic [7:0] op, input logic [A-1:0] addr,
                                          input logic [D-1:0] data);
    return {data, addr, op};
  endfunction

  function automatic logic [7:0] byte_of(input logic [W-1:0] p, input int k);
    logic [W-1:0] s;
    s = p >> (8 * k);
    return s[7:0];
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    return W'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic logic [W-1:0] echo_of(input logic [W-1:0] c);
    logic [D-1:0] d;
    d = {$urandom, $urandom};
    return {d, c[A+7:0]};
  endfunction

  // first index where tx_log differs from packet p starting at log offset off; -1 if none
  function automatic int bad_byte(input logic [W-1:0] p, input int off);
    for (int k = 0; k < NB; k++) begin
      if (off + k >= tx_log.size()) return k;
      if (tx_log[off + k] !== byte_of(p, k)) return k;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; cmd_v = 1'b0; cmd = '0; tx_ready = 1'b1;
    rx_v = 1'b0; rx = 8'h00; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tx_log.delete();
    issued.delete();
  endtask

  task automatic issue(input logic [W-1:0] p, output int unsigned acc_cyc);
    int n;
    n = 0;
    cmd = p; cmd_v = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL issue_wait: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
      cmd_v = 1'b0; acc_cyc = cyc;
    end else begin
      @(posedge clk); #1;
      acc_cyc = cyc;
      cmd_v = 1'b0;
      issued.push_back(p);
    end
  endtask

  task automatic drain_tx();
    int n;
    n = 0;
    tx_ready = 1'b1;
    while (tx_v && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (tx_v) begin
      checks++; errors++;
      $display("FAIL drain_tx: tx_v=%0b after %0d cycles, required 0", tx_v, n);
    end
  endtask

  task automatic send_rx(input logic [W-1:0] p, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      rx_v = 1'b1; rx = byte_of(p, k);
      @(posedge clk); #1;
    end
    rx_v = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_v !== 1'b0 || tx !== 8'h00) begin errors++;
      $display("FAIL reset_tx: tx_v=%0b tx=%h, required 0/00", tx_v, tx); end
    checks++; if (resp_v !== 1'b0 || resp !== '0) begin errors++;
      $display("FAIL reset_resp: resp_v=%0b resp=%h, required 0/0", resp_v, resp); end
    checks++; if (outstanding !== 3'd0) begin errors++;
      $display("FAIL reset_outstanding: got %0d, required 0", outstanding); end
    checks++; if ({timeout, mismatch, overflow} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b, required 000", {timeout, mismatch, overflow}); end
    checks++; if (idle !== 1'b1 || cmd_ready !== 1'b1) begin errors++;
      $display("FAIL reset_idle_ready: idle=%0b ready=%0b, required 1/1", idle, cmd_ready); end
  endtask

  task automatic test_basic();
    logic [W-1:0] p, e;
    int unsigned t;
    int bb;
    do_reset();
    p = mk_pkt(8'h02, 40'h00_8000_0000, 64'hAB);
    issue(p, t);
    checks++; if (tx_v !== 1'b1 || tx !== 8'h02) begin errors++;
      $display("FAIL basic_first_byte: tx_v=%0b tx=%h, required 1/02", tx_v, tx); end
    drain_tx();
    bb = bad_byte(p, 0);
    checks++; if (bb != -1 || tx_log.size() != NB) begin errors++;
      $display("FAIL basic_tx_bytes: first bad byte %0d, count %0d, required none/%0d", bb, tx_log.size(), NB); end
    checks++; if (outstanding !== 3'd1) begin errors++;
      $display("FAIL basic_out1: got %0d, required 1", outstanding); end
    e = mk_pkt(8'h02, 40'h00_8000_0000, 64'h0);
    send_rx(e, 0, NB);
    checks++; if (resp_v !== 1'b1 || resp !== e) begin errors++;
      $display("FAIL basic_resp: v=%0b resp=%h, required 1/%h", resp_v, resp, e); end
    checks++; if (outstanding !== 3'd0 || mismatch !== 1'b0) begin errors++;
      $display("FAIL basic_out0: out=%0d mm=%0b, required 0/0", outstanding, mismatch); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if (resp_v !== 1'b0 || idle !== 1'b1) begin errors++;
      $display("FAIL basic_consume: v=%0b idle=%0b, required 0/1", resp_v, idle); end
  endtask

  task automatic test_random_cmds();
    logic [W-1:0] p, e;
    int unsigned t;
    int n, bb;
    bit ok, prev_hold;
    logic [7:0] prev_tx;
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p = rand_pkt();
      tx_log.delete();
      issue(p, t);
      n = 0; ok = 1'b1; prev_hold = 1'b0; prev_tx = 8'h00;
      while (tx_v && n < 300) begin
        if (prev_hold && tx !== prev_tx) ok = 1'b0;
        tx_ready = 1'($urandom_range(0, 1));
        prev_hold = !tx_ready; prev_tx = tx;
        @(posedge clk); #1; n++;
      end
      if (prev_hold || tx_v) ok = 1'b0;
      tx_ready = 1'b1;
      checks++; if (!ok) begin errors++;
        $display("FAIL rand_tx_hold[%0d]: stable=%0b, required 1", i, ok); end
      bb = bad_byte(p, 0);
      checks++; if (bb != -1 || tx_log.size() != NB) begin errors++;
        $display("FAIL rand_tx_bytes[%0d]: first bad byte %0d, count %0d, required none/%0d", i, bb, tx_log.size(), NB); end
      e = echo_of(issued.pop_front());
      send_rx(e, 0, NB);
      checks++; if (resp_v !== 1'b1 || resp !== e || outstanding !== 3'(issued.size())) begin errors++;
        $display("FAIL rand_resp[%0d]: v=%0b resp=%h out=%0d, required 1/%h/%0d", i, resp_v, resp, outstanding, e, issued.size()); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] p1, p2, e1, e2;
    int unsigned t1, t2;
    int b1, b2;
    do_reset();
    resp_ready = 1'b1;
    p1 = rand_pkt(); p2 = rand_pkt();
    issue(p1, t1);
    issue(p2, t2);
    checks++; if (t2 - t1 != NB + 1) begin errors++;
      $display("FAIL b2b_gap: got %0d cycles, required %0d", t2 - t1, NB + 1); end
    checks++; if (outstanding !== 3'd2) begin errors++;
      $display("FAIL b2b_out2: got %0d, required 2", outstanding); end
    drain_tx();
    b1 = bad_byte(p1, 0); b2 = bad_byte(p2, NB);
    checks++; if (b1 != -1 || b2 != -1 || tx_log.size() != 2 * NB) begin errors++;
      $display("FAIL b2b_bytes: bad %0d/%0d count %0d, required none/none/%0d", b1, b2, tx_log.size(), 2 * NB); end
    e1 = echo_of(issued.pop_front());
    e2 = echo_of(issued.pop_front());
    send_rx(e1, 0, NB);
    checks++; if (resp_v !== 1'b1 || resp !== e1) begin errors++;
      $display("FAIL b2b_resp1: v=%0b resp=%h, required 1/%h", resp_v, resp, e1); end
    send_rx(e2, 0, NB);
    checks++; if (resp_v !== 1'b1 || resp !== e2 || outstanding !== 3'd0) begin errors++;
      $display("FAIL b2b_resp2: v=%0b resp=%h out=%0d, required 1/%h/0", resp_v, resp, outstanding, e2); end
  endtask

  task automatic test_outstanding_limit();
    logic [W-1:0] p;
    int unsigned t;
    bit blocked;
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < MAXO; i++) issue(rand_pkt(), t);
    drain_tx();
    checks++; if (outstanding !== 3'(MAXO)) begin errors++;
      $display("FAIL lim_full: got %0d, required %0d", outstanding, MAXO); end
    p = rand_pkt();
    cmd = p; cmd_v = 1'b1; blocked = 1'b1;
    repeat (8) begin
      if (cmd_ready !== 1'b0) blocked = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (!blocked || outstanding !== 3'(MAXO)) begin errors++;
      $display("FAIL lim_blocked: blocked=%0b out=%0d, required 1/%0d", blocked, outstanding, MAXO); end
    send_rx(echo_of(issued.pop_front()), 0, NB);
    checks++; if (cmd_ready !== 1'b1 || outstanding !== 3'(MAXO - 1)) begin errors++;
      $display("FAIL lim_release: ready=%0b out=%0d, required 1/%0d", cmd_ready, outstanding, MAXO - 1); end
    @(posedge clk); #1;
    cmd_v = 1'b0;
    issued.push_back(p);
    checks++; if (outstanding !== 3'(MAXO) || tx_v !== 1'b1) begin errors++;
      $display("FAIL lim_accept5: out=%0d tx_v=%0b, required %0d/1", outstanding, tx_v, MAXO); end
    drain_tx();
    send_rx(echo_of(issued.pop_front()), 0, NB);
    p = echo_of(issued.pop_front());
    send_rx(p, 0, NB - 1);
    cmd = rand_pkt(); cmd_v = 1'b1;
    rx_v = 1'b1; rx = byte_of(p, NB - 1);
    @(posedge clk); #1;
    rx_v = 1'b0; cmd_v = 1'b0;
    checks++; if (outstanding !== 3'(MAXO - 1) || tx_v !== 1'b1) begin errors++;
      $display("FAIL lim_simul: out=%0d tx_v=%0b, required %0d/1", outstanding, tx_v, MAXO - 1); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] e1, e2;
    int unsigned t;
    do_reset();
    issue(rand_pkt(), t);
    issue(rand_pkt(), t);
    drain_tx();
    e1 = echo_of(issued.pop_front());
    e2 = echo_of(issued.pop_front());
    send_rx(e1, 0, NB);
    checks++; if (resp_v !== 1'b1 || resp !== e1 || overflow !== 1'b0) begin errors++;
      $display("FAIL ovf_first: v=%0b resp=%h ovf=%0b, required 1/%h/0", resp_v, resp, overflow, e1); end
    send_rx(e2, 0, NB);
    checks++; if (resp_v !== 1'b1 || resp !== e1 || overflow !== 1'b1 || outstanding !== 3'd0) begin errors++;
      $display("FAIL ovf_drop: v=%0b resp=%h ovf=%0b out=%0d, required 1/%h/1/0", resp_v, resp, overflow, outstanding, e1); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_v !== 1'b0 || overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_sticky: v=%0b ovf=%0b, required 0/1", resp_v, overflow); end
  endtask

  task automatic test_mismatch();
    logic [W-1:0] e, u;
    int unsigned t;
    do_reset();
    resp_ready = 1'b1;
    issue(mk_pkt(8'h02, 40'h00_8000_0000, {$urandom, $urandom}), t);
    drain_tx();
    e = mk_pkt(8'h02, 40'h00_8000_0008, {$urandom, $urandom});
    send_rx(e, 0, NB);
    checks++; if (resp_v !== 1'b1 || resp !== e || mismatch !== EXP_MM) begin errors++;
      $display("FAIL mm_addr: v=%0b resp=%h mm=%0b, required 1/%h/%0b", resp_v, resp, mismatch, e, EXP_MM); end
    u = rand_pkt();
    send_rx(u, 0, NB);
    checks++; if (resp !== u || outstanding !== 3'd0 || mismatch !== EXP_MM) begin errors++;
      $display("FAIL mm_unsolicited: resp=%h out=%0d mm=%0b, required %h/0/%0b", resp, outstanding, mismatch, u, EXP_MM); end
  endtask

  task automatic test_timeout();
    logic [W-1:0] e;
    int unsigned t;
    do_reset();
    resp_ready = 1'b1;
    issue(rand_pkt(), t);
    drain_tx();
    send_rx(rand_pkt(), 0, 5);
    repeat (TO - 1) @(posedge clk);
    #1;
    checks++; if (timeout !== 1'b0) begin errors++;
      $display("FAIL to_early: timeout=%0b after %0d idle cycles, required 0", timeout, TO - 1); end
    @(posedge clk); #1;
    checks++; if (timeout !== 1'b1 || outstanding !== 3'd1) begin errors++;
      $display("FAIL to_fire: timeout=%0b out=%0d, required 1/1", timeout, outstanding); end
    e = echo_of(issued.pop_front());
    send_rx(e, 0, NB);
    checks++; if (resp_v !== 1'b1 || resp !== e || outstanding !== 3'd0 || mismatch !== 1'b0) begin errors++;
      $display("FAIL to_resync: v=%0b resp=%h out=%0d mm=%0b, required 1/%h/0/0", resp_v, resp, outstanding, mismatch, e); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] p;
    int unsigned t;
    do_reset();
    issue(rand_pkt(), t);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx_v !== 1'b0 || tx !== 8'h00 || outstanding !== 3'd0 || idle !== 1'b1) begin errors++;
      $display("FAIL rst_mid_tx: tx_v=%0b tx=%h out=%0d idle=%0b, required 0/00/0/1", tx_v, tx, outstanding, idle); end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (tx_v !== 1'b0 || tx_log.size() != 6) begin errors++;
      $display("FAIL rst_no_bytes: tx_v=%0b bytes=%0d, required 0/6", tx_v, tx_log.size()); end
    send_rx(rand_pkt(), 0, 7);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    p = rand_pkt();
    send_rx(p, 0, NB);
    checks++; if (resp_v !== 1'b1 || resp !== p) begin errors++;
      $display("FAIL rst_mid_rx: v=%0b resp=%h, required 1/%h", resp_v, resp, p); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_cmds();
    test_back_to_back();
    test_outstanding_limit();
    test_overflow();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
